// File: rtl/rr_req_arbiter.sv
// ---------------------------------------------------------------------------
// rr_req_arbiter
//   Round-robin arbiter that shares one resource among N requesters.
//   A grant is held while its owner keeps requesting, but never longer than
//   MAX_HOLD consecutive cycles. Priority rotates: the search for the next
//   winner starts at a pointer that moves past the previous owner, so no
//   requester can starve.
//
// Ports
//   clk        in   1     rising-edge clock
//   rst        in   1     asynchronous, active-high reset
//   req        in   N     request bits, req[i]=1 -> requester i wants access
//   gnt        out  N     one-hot grant, all zero when idle
//   gnt_idx    out  IDXW  binary index of the owner (valid when gnt_valid=1)
//   gnt_valid  out  1     a grant is active (equals |gnt)
//   timeout    out  1     one-cycle pulse: grant revoked by the MAX_HOLD limit
// ---------------------------------------------------------------------------
module rr_req_arbiter #(
    parameter int N        = 8,
    parameter int IDXW     = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(N - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          state_q;
    logic [IDXW-1:0] ptr_q;
    logic [HW-1:0]   hold_cnt_q;
    logic [N-1:0]    gnt_q;
    logic [IDXW-1:0] gnt_idx_q;
    logic            gnt_valid_q;
    logic            timeout_q;

    logic            win_found_d;
    logic [IDXW-1:0] win_idx_d;
    logic [IDXW-1:0] ptr_d;
    logic            owner_req_d;

    // Rotating priority search: returns {found, index} of the first set bit
    // visiting ptr, ptr+1, ..., N-1, 0, ..., ptr-1. The loop runs from the
    // farthest offset down so the nearest set bit is the last one written.
    function automatic logic [IDXW:0] rr_pick(input logic [N-1:0]    r,
                                              input logic [IDXW-1:0] p);
        logic [IDXW:0]   res;
        logic [IDXW:0]   sum;
        logic [IDXW-1:0] idx;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, p} + (IDXW + 1)'(k);
            if (sum >= (IDXW + 1)'(N)) begin
                sum = sum - (IDXW + 1)'(N);
            end else begin
                sum = sum;
            end
            idx = sum[IDXW-1:0];
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Winner of the current request vector, next pointer after the owner,
    // and whether the current owner is still requesting.
    always_comb begin
        {win_found_d, win_idx_d} = rr_pick(req, ptr_q);
        if (gnt_idx_q == IDX_LAST) begin
            ptr_d = '0;
        end else begin
            ptr_d = gnt_idx_q + IDXW'(1);
        end
        owner_req_d = req[gnt_idx_q];
    end

    // Arbitration FSM with registered grant outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    timeout_q <= 1'b0;
                    if (win_found_d) begin
                        gnt_q       <= {{(N-1){1'b0}}, 1'b1} << win_idx_d;
                        gnt_idx_q   <= win_idx_d;
                        gnt_valid_q <= 1'b1;
                        hold_cnt_q  <= '0;
                        state_q     <= ST_GRANT;
                    end else begin
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    // Releasing takes precedence over the hold limit: a
                    // voluntary drop on the last allowed cycle is no timeout.
                    if (!owner_req_d) begin
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        timeout_q   <= 1'b0;
                        ptr_q       <= ptr_d;
                        state_q     <= ST_IDLE;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        timeout_q   <= 1'b1;
                        ptr_q       <= ptr_d;
                        state_q     <= ST_IDLE;
                    end else begin
                        hold_cnt_q  <= hold_cnt_q + HW'(1);
                        timeout_q   <= 1'b0;
                        state_q     <= ST_GRANT;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    gnt_q       <= '0;
                    gnt_valid_q <= 1'b0;
                    timeout_q   <= 1'b0;
                    hold_cnt_q  <= '0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_req_arbiter.sv
module tb_rr_req_arbiter;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int MH = 6;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_valid;
    logic          timeout;

    int checks = 0;
    int errors = 0;

    // Reference model: current owner (-1 = none), rotating pointer,
    // number of cycles the owner has held the grant, timeout pulse.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    int m_to    = 0;

    rr_req_arbiter #(.N(N), .IDXW(IW), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_to    = 0;
    endtask

    // One clock edge of the arbitration rules applied to sampled request r.
    task automatic m_step(input logic [N-1:0] r);
        int idx;
        if (m_owner < 0) begin
            m_to = 0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (m_owner < 0 && ((r >> idx) & 8'd1) != 8'd0) begin
                    m_owner = idx;
                    m_held  = 1;
                end
            end
        end else if (((r >> m_owner) & 8'd1) == 8'd0) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_to    = 0;
        end else if (m_held == MH) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_to    = 1;
        end else begin
            m_held++;
            m_to = 0;
        end
    endtask

    task automatic compare_model(input string tag);
        logic [N-1:0] eg;
        eg = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
        check({tag, ".gnt"}, 32'(gnt), 32'(eg));
        check({tag, ".valid"}, 32'(gnt_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
        check({tag, ".timeout"}, 32'(timeout), 32'(m_to));
        if (m_owner >= 0) check({tag, ".idx"}, 32'(gnt_idx), 32'(m_owner));
    endtask

    // Drive req away from the edge, advance one edge, then compare.
    task automatic step(input logic [N-1:0] r, input string tag);
        @(negedge clk);
        req = r;
        @(posedge clk);
        m_step(r);
        #1;
        compare_model(tag);
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        req = '0;
        #1;
        m_reset();
        compare_model(tag);
        check({tag, ".idx0"}, 32'(gnt_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] r;
        rst = 1'b0;
        req = '0;
        #1;
        do_reset("reset");

        // Single requester.
        step(8'h08, "single_rise");
        check("single_idx3", 32'(gnt_idx), 32'd3);
        for (int i = 0; i < 4; i++) step(8'h08, "single_hold");
        step(8'h00, "single_fall");
        check("single_gnt0", 32'(gnt), 32'd0);

        // Fairness: everyone requests, owner drops after 2 granted cycles.
        do_reset("reset_fair");
        for (int k = 0; k < 9; k++) begin
            step(8'hFF, "fair_grant");
            check("fair_seq", 32'(gnt_idx), 32'(k % N));
            step(8'hFF, "fair_hold");
            r = 8'hFF & ~(8'd1 << (k % N));
            step(r, "fair_drop");
        end

        // Pointer wrap from 7 to 0.
        do_reset("reset_wrap");
        step(8'h40, "wrap_g6");
        step(8'h00, "wrap_rel6");
        step(8'h81, "wrap_g7");
        check("wrap_first7", 32'(gnt), 32'h80);
        step(8'h01, "wrap_rel7");
        step(8'h01, "wrap_g0");
        check("wrap_then0", 32'(gnt), 32'h01);

        // Hold timeout with req held constant.
        do_reset("reset_to");
        for (int i = 0; i < MH; i++) begin
            step(8'h24, "to_hold");
            check("to_gnt04", 32'(gnt), 32'h04);
        end
        step(8'h24, "to_revoke");
        check("to_pulse", 32'(timeout), 32'd1);
        step(8'h24, "to_next");
        check("to_gnt20", 32'(gnt), 32'h20);
        check("to_cleared", 32'(timeout), 32'd0);

        // Reset in the middle of a grant.
        do_reset("reset_mid0");
        step(8'h10, "mid_g4");
        check("mid_gnt10", 32'(gnt), 32'h10);
        do_reset("reset_mid");
        step(8'h11, "mid_after");
        check("mid_idx0", 32'(gnt_idx), 32'd0);

        // Idle hold keeps the pointer (now 1 after releasing 0).
        step(8'h00, "idle_rel");
        for (int i = 0; i < 20; i++) step(8'h00, "idle");
        step(8'h03, "idle_ptr");
        check("idle_ptr_kept", 32'(gnt_idx), 32'd1);

        // Randomized traffic against the model.
        do_reset("reset_rand");
        for (int i = 0; i < 600; i++) begin
            r = N'($urandom);
            if ($urandom_range(0, 9) == 0) r = '0;
            if (m_owner >= 0 && $urandom_range(0, 9) < 8) r = r | (8'd1 << m_owner);
            step(r, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
